usb_tx_encoder: RTL and testbench

//  Bit-level USB full-speed transmit stage; sits directly downstream of the USB transmit controller.

---
 rtl/usb_tx_encoder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder
//   Bit-level USB full-speed transmit stage. Serialises bytes LSB-first at one
//   bit per CLKS_PER_BIT clocks, stuffs a 0 after six consecutive 1s,
//   NRZI-encodes onto D+/D- and generates EOP (SE0, SE0, J).
//
//   Optional feature macro: USB_TX_SYNC_EN
//     defined   -> the first byte after reset/EOP is preceded by an internal
//                  SYNC pattern (0x80); no byte_sent is emitted for SYNC.
//     undefined -> upstream supplies SYNC as the first byte of each packet.
//
// Ports
//   clk          in  system clock, rising edge
//   n_rst        in  asynchronous active-low reset
//   tx_data      in  [7:0] byte to transmit, captured on load_enable
//   load_enable  in  capture tx_data into the holding register, set pending
//   tx_enable    in  permission to start shifting the pending byte
//   create_eop   in  end-of-packet request, latched until served
//   dplus_out    out D+ line level
//   dminus_out   out D- line level
//   byte_sent    out 1-cycle pulse at the start of the last data bit of a byte
//   tx_hold      out 1-cycle pulse at the start of a stuffed-bit period
//   eop_done     out 1-cycle pulse on the last cycle of the EOP J bit
//   tx_busy      out high whenever the encoder is not idle
//
// All outputs are registered and lag the internal state by one clock, so a
// line level, its associated pulse and tx_busy always line up with each other.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       load_enable,
    input  logic       tx_enable,
    input  logic       create_eop,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       byte_sent,
    output logic       tx_hold,
    output logic       eop_done,
    output logic       tx_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_STUFF   = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [TW-1:0] bit_timer_r, bit_timer_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [2:0]    ones_cnt_r, ones_cnt_s;
    logic [7:0]    shift_reg_r, shift_reg_s;
    logic [7:0]    hold_reg_r;
    logic          pending_r, pending_s;
    logic          eop_req_r, eop_req_s;
    logic          level_r, level_s;        // NRZI level, 1 = J
    logic          sync_active_r, sync_active_s;
    logic          dplus_r, dplus_s, dminus_r, dminus_s;
    logic          byte_sent_r, byte_sent_s;
    logic          tx_hold_r, tx_hold_s;
    logic          eop_done_r, eop_done_s;
    logic          tx_busy_r;
    logic          timer_zero_s, timer_end_s, start_byte_s, byte_done_s;

    // Next-state, datapath and output decode for the transmit FSM.
    always_comb begin
        state_s       = state_r;
        bit_timer_s   = bit_timer_r;
        bit_idx_s     = bit_idx_r;
        ones_cnt_s    = ones_cnt_r;
        shift_reg_s   = shift_reg_r;
        pending_s     = pending_r;
        eop_req_s     = eop_req_r | create_eop;
        level_s       = level_r;
        sync_active_s = sync_active_r;
        dplus_s       = dplus_r;
        dminus_s      = dminus_r;
        byte_sent_s   = 1'b0;
        tx_hold_s     = 1'b0;
        eop_done_s    = 1'b0;
        byte_done_s   = 1'b0;
        timer_zero_s  = (bit_timer_r == '0);
        timer_end_s   = (bit_timer_r == TW'(CLKS_PER_BIT - 1));
        start_byte_s  = pending_r && tx_enable;

        case (state_r)
            ST_IDLE, ST_WAIT: begin
                bit_timer_s = '0;
                if (start_byte_s) begin
                    state_s   = ST_SHIFT;
                    bit_idx_s = 3'd0;
`ifdef USB_TX_SYNC_EN
                    if (state_r == ST_IDLE) begin
                        // SYNC goes first; the pending byte stays queued behind it.
                        shift_reg_s   = 8'h80;
                        sync_active_s = 1'b1;
                    end else begin
                        shift_reg_s   = hold_reg_r;
                        pending_s     = 1'b0;
                        sync_active_s = 1'b0;
                    end
`else
                    shift_reg_s = hold_reg_r;
                    pending_s   = 1'b0;
`endif
                end else if (eop_req_r && !pending_r) begin
                    state_s   = ST_EOP_SE0;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SHIFT: begin
                bit_timer_s = timer_end_s ? '0 : bit_timer_r + TW'(1);
                if (timer_zero_s) begin
                    if (shift_reg_r[bit_idx_r]) begin
                        ones_cnt_s = ones_cnt_r + 3'd1;
                    end else begin
                        level_s    = ~level_r;
                        ones_cnt_s = 3'd0;
                    end
                    dplus_s     = level_s;
                    dminus_s    = ~level_s;
                    byte_sent_s = (bit_idx_r == 3'd7) && !sync_active_r;
                end else if (timer_end_s) begin
                    if (ones_cnt_r == 3'd6) begin
                        state_s = ST_STUFF;
                    end else if (bit_idx_r != 3'd7) begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end else begin
                        byte_done_s = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_STUFF: begin
                bit_timer_s = timer_end_s ? '0 : bit_timer_r + TW'(1);
                if (timer_zero_s) begin
                    level_s    = ~level_r;
                    ones_cnt_s = 3'd0;
                    dplus_s    = ~level_r;
                    dminus_s   = level_r;
                    tx_hold_s  = 1'b1;
                end else if (timer_end_s) begin
                    if (bit_idx_r != 3'd7) begin
                        state_s   = ST_SHIFT;
                        bit_idx_s = bit_idx_r + 3'd1;
                    end else begin
                        byte_done_s = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_EOP_SE0: begin
                bit_timer_s = timer_end_s ? '0 : bit_timer_r + TW'(1);
                if (timer_zero_s) begin
                    dplus_s  = 1'b0;
                    dminus_s = 1'b0;
                end else if (timer_end_s) begin
                    // bit_idx counts the two SE0 bit periods.
                    if (bit_idx_r == 3'd0) begin
                        bit_idx_s = 3'd1;
                    end else begin
                        state_s   = ST_EOP_J;
                        bit_idx_s = 3'd0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_EOP_J: begin
                bit_timer_s = timer_end_s ? '0 : bit_timer_r + TW'(1);
                if (timer_zero_s) begin
                    dplus_s  = 1'b1;
                    dminus_s = 1'b0;
                end else if (timer_end_s) begin
                    state_s    = ST_IDLE;
                    eop_done_s = 1'b1;
                    ones_cnt_s = 3'd0;
                    level_s    = 1'b1;
                    eop_req_s  = create_eop;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Byte finished (including any trailing stuff bit): chain, end or park.
        if (byte_done_s) begin
            bit_idx_s = 3'd0;
            if (start_byte_s) begin
                state_s       = ST_SHIFT;
                shift_reg_s   = hold_reg_r;
                pending_s     = 1'b0;
                sync_active_s = 1'b0;
            end else if (eop_req_r) begin
                state_s = ST_EOP_SE0;
            end else begin
                state_s = ST_WAIT;
            end
        end else begin
            bit_idx_s = bit_idx_s;
        end

        // A new load always wins over the consumption of the previous byte.
        if (load_enable) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_s;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= ST_IDLE;
            bit_timer_r   <= '0;
            bit_idx_r     <= 3'd0;
            ones_cnt_r    <= 3'd0;
            shift_reg_r   <= 8'h00;
            hold_reg_r    <= 8'h00;
            pending_r     <= 1'b0;
            eop_req_r     <= 1'b0;
            level_r       <= 1'b1;
            sync_active_r <= 1'b0;
            dplus_r       <= 1'b1;
            dminus_r      <= 1'b0;
            byte_sent_r   <= 1'b0;
            tx_hold_r     <= 1'b0;
            eop_done_r    <= 1'b0;
            tx_busy_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            bit_timer_r   <= bit_timer_s;
            bit_idx_r     <= bit_idx_s;
            ones_cnt_r    <= ones_cnt_s;
            shift_reg_r   <= shift_reg_s;
            hold_reg_r    <= load_enable ? tx_data : hold_reg_r;
            pending_r     <= pending_s;
            eop_req_r     <= eop_req_s;
            level_r       <= level_s;
            sync_active_r <= sync_active_s;
            dplus_r       <= dplus_s;
            dminus_r      <= dminus_s;
            byte_sent_r   <= byte_sent_s;
            tx_hold_r     <= tx_hold_s;
            eop_done_r    <= eop_done_s;
            tx_busy_r     <= (state_r != ST_IDLE);
        end
    end

    assign dplus_out  = dplus_r;
    assign dminus_out = dminus_r;
    assign byte_sent  = byte_sent_r;
    assign tx_hold    = tx_hold_r;
    assign eop_done   = eop_done_r;
    assign tx_busy    = tx_busy_r;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Testbench for usb_tx_encoder. A behavioural reference encoder turns each
// packet into a queue of expected bit-period symbols (line level plus the
// pulses expected in that period); a monitor pops and compares one symbol per
// bit period once the transmission starts.
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       load_enable;
    logic       tx_enable;
    logic       create_eop;
    logic       dplus_out;
    logic       dminus_out;
    logic       byte_sent;
    logic       tx_hold;
    logic       eop_done;
    logic       tx_busy;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_data     (tx_data),
        .load_enable (load_enable),
        .tx_enable   (tx_enable),
        .create_eop  (create_eop),
        .dplus_out   (dplus_out),
        .dminus_out  (dminus_out),
        .byte_sent   (byte_sent),
        .tx_hold     (tx_hold),
        .eop_done    (eop_done),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] line;   // {D+, D-}
        bit         bs;     // byte_sent at first cycle of period
        bit         th;     // tx_hold at first cycle of period
        bit         eo;     // eop_done at last cycle of period
    } sym_t;

    sym_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   model_level = 1'b1;
    int   model_ones  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_sym(input logic [1:0] line, input bit bs, input bit th, input bit eo);
        sym_t s;
        s.line = line;
        s.bs   = bs;
        s.th   = th;
        s.eo   = eo;
        exp_q.push_back(s);
    endtask

    task automatic push_bit(input bit b, input bit bs);
        if (!b) begin
            model_level = ~model_level;
            model_ones  = 0;
        end else begin
            model_ones++;
        end
        push_sym({model_level, ~model_level}, bs, 1'b0, 1'b0);
        if (model_ones == 6) begin
            model_level = ~model_level;
            model_ones  = 0;
            push_sym({model_level, ~model_level}, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit counted);
        for (int i = 0; i < 8; i++) push_bit(b[i], counted && (i == 7));
    endtask

    task automatic push_eop();
        push_sym(2'b00, 1'b0, 1'b0, 1'b0);
        push_sym(2'b00, 1'b0, 1'b0, 1'b0);
        push_sym(2'b10, 1'b0, 1'b0, 1'b1);
        model_level = 1'b1;
        model_ones  = 0;
    endtask

    // Compare one symbol per bit period; start on tx_busy rise or on SE0.
    task automatic monitor(input bit wait_se0);
        int         to = 0;
        int         k  = 0;
        sym_t       s;
        logic [7:0] bsv, thv, eov;
        logic [1:0] ln;
        while (!(wait_se0 ? ({dplus_out, dminus_out} == 2'b00) : (tx_busy == 1'b1)) && to < 400) begin
            @(negedge clk);
            to++;
        end
        if (to >= 400) begin
            check("start_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0) begin
                s  = exp_q.pop_front();
                ln = 2'bxx;
                for (int o = 0; o < CPB; o++) begin
                    bsv[o] = byte_sent;
                    thv[o] = tx_hold;
                    eov[o] = eop_done;
                    if (o == CPB / 2) ln = {dplus_out, dminus_out};
                    @(negedge clk);
                end
                check($sformatf("line_p%0d", k), {30'd0, ln}, {30'd0, s.line});
                check($sformatf("pulses_p%0d", k), {8'd0, bsv, thv, eov},
                      {8'd0, (s.bs ? 8'h01 : 8'h00), (s.th ? 8'h01 : 8'h00), (s.eo ? 8'h80 : 8'h00)});
                k++;
            end
        end
    endtask

    // eop_mode: 0 none, 1 with last load, 2 a few cycles after last load.
    task automatic drive_bytes(input logic [7:0] bytes[$], input int eop_mode);
        int to;
        for (int i = 0; i < bytes.size(); i++) begin
            if (i > 0) begin
                to = 0;
                while (!byte_sent && to < 300) begin
                    @(negedge clk);
                    to++;
                end
                if (to >= 300) check("byte_sent_timeout", 32'd0, 32'd1);
            end
            tx_data     = bytes[i];
            load_enable = 1'b1;
            create_eop  = (eop_mode == 1) && (i == bytes.size() - 1);
            @(negedge clk);
            load_enable = 1'b0;
            create_eop  = 1'b0;
        end
        if (eop_mode == 2) begin
            repeat (10) @(negedge clk);
            create_eop = 1'b1;
            @(negedge clk);
            create_eop = 1'b0;
        end
    endtask

    task automatic run_packet(input logic [7:0] bytes[$], input int eop_mode);
`ifdef USB_TX_SYNC_EN
        push_byte(8'h80, 1'b0);
`endif
        foreach (bytes[i]) push_byte(bytes[i], 1'b1);
        if (eop_mode != 0) push_eop();
        fork
            monitor(1'b0);
            drive_bytes(bytes, eop_mode);
        join
        if (eop_mode != 0) begin
            check("busy_after_eop", {31'd0, tx_busy}, 32'd0);
            check("line_after_eop", {30'd0, dplus_out, dminus_out}, 32'd2);
        end
    endtask

    initial begin
        logic [7:0] pk[$];
        logic [1:0] ln0;
        bit         changed;
        int         to;

        n_rst       = 1'b0;
        tx_data     = 8'h00;
        load_enable = 1'b0;
        tx_enable   = 1'b0;
        create_eop  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line", {30'd0, dplus_out, dminus_out}, 32'd2);
        check("rst_busy_pulses", {28'd0, tx_busy, byte_sent, tx_hold, eop_done}, 32'd0);
        n_rst     = 1'b1;
        tx_enable = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_start", {31'd0, tx_busy}, 32'd0);

        // 0x00, no EOP: toggles every bit, then parks in WAIT.
        pk.delete(); pk.push_back(8'h00);
        run_packet(pk, 0);
        ln0 = {dplus_out, dminus_out};
        check("wait_level", {30'd0, ln0}, {30'd0, model_level, ~model_level});
        changed = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if ({dplus_out, dminus_out} != ln0 || !tx_busy) changed = 1'b1;
        end
        check("wait_hold", {31'd0, changed}, 32'd0);
        push_eop();
        fork
            monitor(1'b1);
            begin
                create_eop = 1'b1;
                @(negedge clk);
                create_eop = 1'b0;
            end
        join
        check("busy_after_wait_eop", {31'd0, tx_busy}, 32'd0);

        // 0xFF: stuff after six ones, with EOP loaded together.
        pk.delete(); pk.push_back(8'hFF);
        run_packet(pk, 1);

        // 0x3F then 0x01 back to back.
        pk.delete(); pk.push_back(8'h3F); pk.push_back(8'h01);
        run_packet(pk, 1);

        // 0xA5 with create_eop arriving mid-byte.
        pk.delete(); pk.push_back(8'hA5);
        run_packet(pk, 2);

        // Random multi-byte packets.
        for (int r = 0; r < 3; r++) begin
            pk.delete();
            for (int j = 0; j < 3; j++) pk.push_back(8'($urandom_range(0, 255)));
            if (r == 0) pk[1] = 8'hFE;
            run_packet(pk, 1);
        end

        // Reset in the middle of a byte.
        tx_data     = 8'h55;
        load_enable = 1'b1;
        @(negedge clk);
        load_enable = 1'b0;
        to = 0;
        while (!tx_busy && to < 100) begin
            @(negedge clk);
            to++;
        end
        check("mid_rst_started", {31'd0, tx_busy}, 32'd1);
        repeat (20) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_line", {30'd0, dplus_out, dminus_out}, 32'd2);
        check("mid_rst_busy_pulses", {28'd0, tx_busy, byte_sent, tx_hold, eop_done}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        model_level = 1'b1;
        model_ones  = 0;
        repeat (30) @(negedge clk);
        check("post_rst_idle", {29'd0, tx_busy, dplus_out, dminus_out}, 32'd2);

        // Recovery after reset.
        pk.delete(); pk.push_back(8'h5A);
        run_packet(pk, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
